// File: rtl/sfa_pkg.sv
// sfa_pkg: shared state type and signed-add overflow helper for the frame accumulator.
package sfa_pkg;
  typedef enum logic {ACCUM, HOLD} sfa_state_t;
  function automatic logic sfa_add_ovf(input logic a_sign, input logic b_sign, input logic s_sign);
    return (a_sign == b_sign) && (s_sign != a_sign);
  endfunction
endpackage

// File: rtl/sign_extend.sv
// sign_extend: widens a two's-complement value by replicating its sign bit.
module sign_extend #(
  parameter int NUM_INPUTS = 8,
  parameter int NUM_OUTPUTS = 16
) (
  input  logic [NUM_INPUTS-1:0]  in_bits,
  output logic [NUM_OUTPUTS-1:0] out_bits
);
  assign out_bits = {{(NUM_OUTPUTS-NUM_INPUTS){in_bits[NUM_INPUTS-1]}}, in_bits};
endmodule

// File: rtl/signed_frame_accumulator.sv
// signed_frame_accumulator: sums NUM_SAMPLES sign-extended samples per frame, with sticky overflow.
module signed_frame_accumulator
  import sfa_pkg::*;
#(
  parameter int IN_W = 16,
  parameter int ACC_W = 32,
  parameter int NUM_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);
  localparam int CNT_W = $clog2(NUM_SAMPLES+1);
  sfa_state_t state, state_nxt;
  logic [ACC_W-1:0] acc, ext, sum;
  logic [CNT_W-1:0] cnt;
  logic ovf, step_ovf, accept, last;
  sign_extend #(.NUM_INPUTS(IN_W), .NUM_OUTPUTS(ACC_W)) u_ext (
    .in_bits (in_data),
    .out_bits(ext)
  );
  assign sum = acc + ext;
  always_comb begin
    in_ready = state == ACCUM;
    out_valid = state == HOLD;
    accept = in_valid && in_ready && !clr;
    last = cnt == CNT_W'(NUM_SAMPLES-1);
    step_ovf = sfa_add_ovf(acc[ACC_W-1], ext[ACC_W-1], sum[ACC_W-1]);
    state_nxt = clr ? ACCUM : out_valid ? (out_ready ? ACCUM : HOLD) : (accept && last ? HOLD : ACCUM);
  end
  always_ff @(posedge clk)
    state <= !rst_n ? ACCUM : state_nxt;
  // clr wipes the frame in progress but leaves the last presented result readable
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      out_data <= '0;
      out_ovf <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept && last) begin
      out_data <= sum;
      out_ovf <= ovf | step_ovf;
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (accept) begin
      acc <= sum;
      cnt <= cnt + 1'b1;
      ovf <= ovf | step_ovf;
    end
  end
endmodule

// File: tb/tb_signed_frame_accumulator.sv
// tb_signed_frame_accumulator: directed and randomized checks of three accumulator configurations.
module tb_signed_frame_accumulator;
  logic clk = 0, rst_n = 0;
  logic v0 = 0, c0 = 0, r0 = 0, ir0, ov0, of0;
  logic [15:0] i0 = 0;
  logic [31:0] od0;
  logic v1 = 0, c1 = 0, r1 = 0, ir1, ov1, of1;
  logic [15:0] i1 = 0;
  logic [31:0] od1;
  logic v2 = 0, c2 = 0, r2 = 0, ir2, ov2, of2;
  logic [15:0] i2 = 0;
  logic [16:0] od2;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  signed_frame_accumulator dut0 (
    .clk(clk), .rst_n(rst_n), .clr(c0), .in_valid(v0), .in_ready(ir0), .in_data(i0),
    .out_valid(ov0), .out_ready(r0), .out_data(od0), .out_ovf(of0));
  signed_frame_accumulator #(.NUM_SAMPLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(c1), .in_valid(v1), .in_ready(ir1), .in_data(i1),
    .out_valid(ov1), .out_ready(r1), .out_data(od1), .out_ovf(of1));
  signed_frame_accumulator #(.ACC_W(17)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(c2), .in_valid(v2), .in_ready(ir2), .in_data(i2),
    .out_valid(ov2), .out_ready(r2), .out_data(od2), .out_ovf(of2));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // True integer sum of the frame, wrapped into w-bit signed range whenever a partial sum leaves it
  function automatic longint model(input logic [15:0] s[4], input int w, output bit o);
    longint a, lo, hi;
    a = 0;
    lo = -(longint'(1) << (w-1));
    hi = (longint'(1) << (w-1)) - 1;
    o = 0;
    for (int k = 0; k < 4; k++) begin
      a += longint'($signed(s[k]));
      if (a > hi) begin o = 1; a -= longint'(1) << w; end
      else if (a < lo) begin o = 1; a += longint'(1) << w; end
    end
    return a;
  endfunction
  task automatic test_reset;
    rst_n = 0;
    tick;
    rst_n = 1;
    checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %b exp 1", ir0); end
    checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %b exp 0", ov0); end
    checks++; if (od0 !== 32'h0) begin failures++; $display("FAIL reset_out_data got %h exp 0", od0); end
    checks++; if (of0 !== 1'b0) begin failures++; $display("FAIL reset_out_ovf got %b exp 0", of0); end
    checks++; if (ov1 !== 1'b0 || ov2 !== 1'b0) begin failures++; $display("FAIL reset_others got %b%b exp 00", ov1, ov2); end
  endtask
  task automatic test_basic;
    logic [15:0] s[4] = '{16'h0001, 16'hFFFE, 16'h0003, 16'hFFFC};
    r0 = 1;
    for (int k = 0; k < 4; k++) begin
      v0 = 1; i0 = s[k];
      tick;
    end
    v0 = 0;
    checks++; if (ov0 !== 1'b1) begin failures++; $display("FAIL basic_out_valid got %b exp 1", ov0); end
    checks++; if (od0 !== 32'hFFFFFFFE) begin failures++; $display("FAIL basic_out_data got %h exp fffffffe", od0); end
    checks++; if (of0 !== 1'b0) begin failures++; $display("FAIL basic_out_ovf got %b exp 0", of0); end
    checks++; if (ir0 !== 1'b0) begin failures++; $display("FAIL basic_in_ready_hold got %b exp 0", ir0); end
    tick;
    checks++; if (ir0 !== 1'b1 || ov0 !== 1'b0) begin failures++; $display("FAIL basic_release got ir=%b ov=%b exp ir=1 ov=0", ir0, ov0); end
  endtask
  task automatic test_sign_ext;
    r1 = 1; v1 = 1; i1 = 16'h8000;
    tick;
    v1 = 0;
    checks++; if (ov1 !== 1'b1) begin failures++; $display("FAIL sext_out_valid got %b exp 1", ov1); end
    checks++; if (od1 !== 32'hFFFF8000) begin failures++; $display("FAIL sext_out_data got %h exp ffff8000", od1); end
    checks++; if (of1 !== 1'b0) begin failures++; $display("FAIL sext_out_ovf got %b exp 0", of1); end
    tick;
    checks++; if (ov1 !== 1'b0) begin failures++; $display("FAIL sext_release got %b exp 0", ov1); end
  endtask
  task automatic test_backpressure;
    logic [15:0] s[4];
    logic [31:0] e;
    bit o;
    for (int k = 0; k < 4; k++) s[k] = 16'($urandom);
    e = 32'(model(s, 32, o));
    r0 = 0;
    for (int k = 0; k < 4; k++) begin
      v0 = 1; i0 = s[k];
      tick;
    end
    i0 = 16'd9;
    for (int k = 0; k < 5; k++) begin
      checks++; if (ov0 !== 1'b1 || od0 !== e || ir0 !== 1'b0) begin failures++; $display("FAIL bp_hold got ov=%b od=%h ir=%b exp ov=1 od=%h ir=0", ov0, od0, ir0, e); end
      tick;
    end
    r0 = 1;
    tick;
    checks++; if (ir0 !== 1'b1 || ov0 !== 1'b0) begin failures++; $display("FAIL bp_release got ir=%b ov=%b exp ir=1 ov=0", ir0, ov0); end
    tick;
    i0 = 16'd0;
    repeat (3) tick;
    v0 = 0;
    checks++; if (ov0 !== 1'b1 || od0 !== 32'd9) begin failures++; $display("FAIL bp_held_sample got ov=%b od=%h exp ov=1 od=9", ov0, od0); end
    tick;
  endtask
  task automatic test_overflow;
    r2 = 1; v2 = 1; i2 = 16'h7FFF;
    repeat (4) tick;
    v2 = 0;
    checks++; if (ov2 !== 1'b1 || od2 !== 17'h1FFFC) begin failures++; $display("FAIL ovf_data got ov=%b od=%h exp ov=1 od=1fffc", ov2, od2); end
    checks++; if (of2 !== 1'b1) begin failures++; $display("FAIL ovf_flag got %b exp 1", of2); end
    tick;
    v2 = 1; i2 = 16'h0;
    repeat (4) tick;
    v2 = 0;
    checks++; if (od2 !== 17'h0 || of2 !== 1'b0) begin failures++; $display("FAIL ovf_clear got od=%h ovf=%b exp od=0 ovf=0", od2, of2); end
    tick;
  endtask
  task automatic test_clr;
    r0 = 0;
    v0 = 1; i0 = 16'd5; tick;
    i0 = 16'd7; tick;
    c0 = 1; i0 = 16'd100;
    checks++; if (ir0 !== 1'b1) begin failures++; $display("FAIL clr_in_ready got %b exp 1", ir0); end
    tick;
    c0 = 0; i0 = 16'd1;
    repeat (4) tick;
    v0 = 0;
    checks++; if (ov0 !== 1'b1 || od0 !== 32'd4 || of0 !== 1'b0) begin failures++; $display("FAIL clr_frame got ov=%b od=%h ovf=%b exp ov=1 od=4 ovf=0", ov0, od0, of0); end
    c0 = 1;
    tick;
    c0 = 0;
    checks++; if (ov0 !== 1'b0 || ir0 !== 1'b1) begin failures++; $display("FAIL clr_hold_drop got ov=%b ir=%b exp ov=0 ir=1", ov0, ir0); end
    checks++; if (od0 !== 32'd4) begin failures++; $display("FAIL clr_data_kept got %h exp 4", od0); end
  endtask
  task automatic test_mid_reset;
    r0 = 1; v0 = 1; i0 = 16'd3;
    repeat (2) tick;
    rst_n = 0;
    tick;
    rst_n = 1;
    checks++; if (ir0 !== 1'b1 || ov0 !== 1'b0 || od0 !== 32'h0 || of0 !== 1'b0) begin failures++; $display("FAIL midrst_outputs got ir=%b ov=%b od=%h ovf=%b exp 1 0 0 0", ir0, ov0, od0, of0); end
    i0 = 16'd2;
    repeat (4) tick;
    v0 = 0;
    checks++; if (ov0 !== 1'b1 || od0 !== 32'd8) begin failures++; $display("FAIL midrst_frame got ov=%b od=%h exp ov=1 od=8", ov0, od0); end
    tick;
  endtask
  task automatic test_random;
    logic [15:0] s[4];
    logic [16:0] e;
    bit o;
    r2 = 1;
    for (int f = 0; f < 25; f++) begin
      for (int k = 0; k < 4; k++) s[k] = 16'($urandom);
      e = 17'(model(s, 17, o));
      for (int k = 0; k < 4; k++) begin
        v2 = 0;
        repeat ($urandom_range(0, 2)) tick;
        v2 = 1; i2 = s[k];
        checks++; if (ir2 !== 1'b1) begin failures++; $display("FAIL rand_in_ready got %b exp 1", ir2); end
        tick;
      end
      v2 = 0; r2 = 0;
      repeat ($urandom_range(0, 3)) begin
        checks++; if (ov2 !== 1'b1 || od2 !== e || of2 !== o) begin failures++; $display("FAIL rand_hold got ov=%b od=%h ovf=%b exp ov=1 od=%h ovf=%b", ov2, od2, of2, e, o); end
        tick;
      end
      r2 = 1;
      checks++; if (ov2 !== 1'b1 || od2 !== e || of2 !== o) begin failures++; $display("FAIL rand_result got ov=%b od=%h ovf=%b exp ov=1 od=%h ovf=%b", ov2, od2, of2, e, o); end
      tick;
      checks++; if (ov2 !== 1'b0) begin failures++; $display("FAIL rand_release got %b exp 0", ov2); end
    end
  endtask
  initial begin
    #1;
    test_reset;
    test_basic;
    test_sign_ext;
    test_backpressure;
    test_overflow;
    test_clr;
    test_mid_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/signed_frame_accumulator.md
Name: signed_frame_accumulator

Overview:
- Downstream consumer of the sign-extension stage: takes narrow two's-complement samples, widens them to accumulator width, and sums a fixed-length frame of NUM_SAMPLES.
- Presents the frame sum with a sticky overflow flag on a valid/ready output.
- Sits between the narrow sample producers (post-synchroniser data paths) and wide-datapath consumers.

Parameters:
- IN_W, 16, sample width in bits; must be >= 2.
- ACC_W, 32, accumulator and result width; must be > IN_W.
- NUM_SAMPLES, 4, samples per frame; must be >= 1.
- Localparam CNT_W = $clog2(NUM_SAMPLES+1).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- clr  input  1  synchronous frame abort.
- in_valid  input  1  sample present.
- in_ready  output  1  block accepts a sample this cycle.
- in_data  input  IN_W  signed sample.
- out_valid  output  1  frame result present.
- out_ready  input  1  downstream accepts the result.
- out_data  output  ACC_W  signed frame sum.
- out_ovf  output  1  at least one signed overflow occurred in this frame.

Behaviour:
- Reset (rst_n==0 at clk edge):
  - state=ACCUM, acc=0, cnt=0, ovf=0, out_valid=0, out_data=0, out_ovf=0.
  - in_ready follows state, so it reads 1 after reset.
- States:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Widening: in_data is sign-extended to ACC_W, replicating bit IN_W-1 into bits ACC_W-1..IN_W.
- Arithmetic:
  - sum = acc + ext(in_data), computed modulo 2^ACC_W (wrap, no saturation).
  - Overflow = both operands share a sign and sum's sign differs from it; ORed into ovf.
- ACCUM, accept (in_valid & in_ready):
  - If cnt < NUM_SAMPLES-1: acc<=sum, cnt<=cnt+1, ovf<=ovf|overflow.
  - If cnt == NUM_SAMPLES-1: out_data<=sum, out_ovf<=ovf|overflow, acc<=0, cnt<=0, ovf<=0, state<=HOLD.
  - Latency: result visible the cycle after the last sample is accepted.
- ACCUM, in_valid=0: all state holds.
- HOLD:
  - out_data and out_ovf are stable while out_valid=1 and out_ready=0.
  - On out_valid & out_ready: state<=ACCUM, out_valid drops next cycle.
  - No same-cycle acceptance of a new sample; in_ready=0 throughout HOLD. Minimum frame period is therefore NUM_SAMPLES+1 cycles.
- NUM_SAMPLES==1: every accepted sample goes straight to HOLD with out_data = ext(in_data) and out_ovf=0.
- clr (priority below rst_n, above all else):
  - acc=0, cnt=0, ovf=0, state=ACCUM, out_valid=0.
  - out_data and out_ovf hold their values.
  - Any sample presented in the clr cycle is discarded; in_ready stays 1 combinationally in ACCUM, but the sample is not counted.
  - In HOLD, the pending result is dropped without handshake.
- Reset mid-frame: partial sum discarded; next accepted sample starts a fresh frame.
- Handshake rules:
  - in_ready depends only on state, never combinationally on in_valid.
  - out_valid is registered.
  - Upstream may hold in_valid high across HOLD; no sample is lost or double-counted.

Decomposition:
- Package sfa_pkg:
  - State enum typedef sfa_state_t {ACCUM, HOLD}.
  - Function sfa_add_ovf(a, b, s) returning the signed-overflow bit.
- Sub-module: instantiate existing sign_extend (NUM_INPUTS=IN_W, NUM_OUTPUTS=ACC_W) for the widening path.
- Counter, accumulator and FSM stay in this module.

Test Plan:
- Defaults, samples 1, -2, 3, -4 back-to-back, out_ready=1 → one cycle after 4th accept: out_valid=1, out_data=32'hFFFFFFFE, out_ovf=0; in_ready=0 that cycle, 1 the next.
- Sign extension: NUM_SAMPLES=1, in_data=16'h8000 → out_data=32'hFFFF8000.
- Backpressure: out_ready=0 for 5 cycles after frame completes → out_valid/out_data stable, in_ready=0, a held in_valid sample is not consumed; on release, the sample is accepted the cycle after the handshake.
- Overflow: IN_W=16, ACC_W=17, NUM_SAMPLES=4, samples 16'h7FFF ×4 → out_data=17'h1FFFC, out_ovf=1; next frame of zeros → out_ovf=0.
- clr after 2 accepted samples (5, 7), then 1, 1, 1, 1 → out_data=4; clr asserted in HOLD → out_valid=0 next cycle, no handshake needed.
- rst_n low for 1 cycle mid-frame, with in_valid held high → all outputs at reset values; following 4 samples of 2 → out_data=8.
